// File: rtl/m_ifetch_buf.sv
// Instruction-fetch stage: issues in-order word fetches, buffers {pc, ir} pairs in a
// small prefetch queue and hands them to decode; a redirect flushes and kills stale beats.
module m_ifetch_buf #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_redir,
  input  logic [31:0] w_redir_pc,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic        w_imem_gnt,
  input  logic        w_imem_rvalid,
  input  logic [31:0] w_imem_rdata,
  output logic        w_if_valid,
  input  logic        w_if_ready,
  output logic [31:0] w_if_pc,
  output logic [31:0] w_if_ir
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [OW-1:0] OW_ONE  = OW'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] kill;
  logic [OW-1:0] kill_redir;
  logic [OW-1:0] outstanding_nxt;
  logic [31:0]   q_pc [DEPTH];
  logic [31:0]   q_ir [DEPTH];
  logic [31:0]   redir_target;

  logic issue_ok;
  logic fire;
  logic live_beat;
  logic drop;
  logic push;
  logic pop;

  assign count        = wr_ptr - rd_ptr;
  assign redir_target = w_redir_pc & ~32'h3;

  // Issue is throttled so every granted request already owns a queue slot, which
  // also keeps req/addr stable while waiting for grant.
  assign issue_ok = (int'(count) + int'(outstanding) < DEPTH) &&
                    (int'(outstanding) + int'(kill) < MAX_OUTSTANDING);

  assign w_imem_req  = !w_rst && !w_redir && issue_ok;
  assign w_imem_addr = fetch_pc;
  assign fire        = w_imem_req && w_imem_gnt;

  assign live_beat = !w_rst && !w_redir && w_imem_rvalid;
  assign drop      = live_beat && (kill != '0);
  assign push      = live_beat && (kill == '0) && (outstanding != '0);

  assign w_if_valid = !w_rst && !w_redir && (count != '0);
  assign pop        = w_if_valid && w_if_ready;
  assign w_if_pc    = w_if_valid ? q_pc[rd_ptr[AW-1:0]] : 32'h0;
  assign w_if_ir    = w_if_valid ? q_ir[rd_ptr[AW-1:0]] : 32'h0;

  // A beat arriving in the redirect cycle retires one of the older requests.
  assign kill_redir = kill + outstanding -
                      ((w_imem_rvalid && (kill != '0 || outstanding != '0)) ? OW_ONE : '0);

  assign outstanding_nxt = outstanding + (fire ? OW_ONE : '0) - (push ? OW_ONE : '0);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      kill        <= '0;
    end else if (w_redir) begin
      fetch_pc    <= redir_target;
      resp_pc     <= redir_target;
      rd_ptr      <= wr_ptr;
      outstanding <= '0;
      kill        <= kill_redir;
    end else begin
      if (fire)
        fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)
        kill <= kill - OW_ONE;
      outstanding <= outstanding_nxt;
    end
  end

  always_ff @(posedge w_clk) begin
    if (push) begin
      q_pc[wr_ptr[AW-1:0]] <= resp_pc;
      q_ir[wr_ptr[AW-1:0]] <= w_imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge w_clk) disable iff (w_rst) !(push && count == FULL));

endmodule

// File: tb/tb_m_ifetch_buf.sv
// Scoreboard bench for m_ifetch_buf: an in-order memory responder with random grant and
// latency, plus a stream model that expects sequential PCs from the latest start point.
module tb_m_ifetch_buf;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_redir = 1'b0;
  logic [31:0] w_redir_pc = '0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_gnt = 1'b0;
  logic        w_imem_rvalid = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_if_valid;
  logic        w_if_ready = 1'b0;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_ir;

  m_ifetch_buf #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_redir(w_redir), .w_redir_pc(w_redir_pc),
    .w_imem_req(w_imem_req), .w_imem_addr(w_imem_addr), .w_imem_gnt(w_imem_gnt),
    .w_imem_rvalid(w_imem_rvalid), .w_imem_rdata(w_imem_rdata),
    .w_if_valid(w_if_valid), .w_if_ready(w_if_ready), .w_if_pc(w_if_pc), .w_if_ir(w_if_ir)
  );

  always #5 w_clk = ~w_clk;

  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  logic [31:0] model_pc = RESET_PC;
  int checks = 0, passes = 0, pop_cnt = 0, cyc = 0, snap = 0;
  int gnt_pct = 100, extra_lo = 0, extra_hi = 0;
  bit stray = 0, beat_from_pend = 0, rst_seen = 0, hold_pending = 0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    return idx * 32'h9E3779B1 + 32'h13579BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
  endtask

  // The expected stream restarts at the reset PC or redirect target and then counts up by 4.
  task automatic startStream(input logic [31:0] target);
    exp_q.delete();
    model_pc = target & ~32'h3;
  endtask

  task automatic topUp();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] tgt, input bit ready,
                               input int gp, input int elo, input int ehi, input bit inj);
    @(posedge w_clk);
    #1;
    w_rst = rst; w_redir = redir; w_redir_pc = tgt; w_if_ready = ready;
    gnt_pct = gp; extra_lo = elo; extra_hi = ehi; stray = inj;
    if (rst) startStream(RESET_PC);
    else if (redir) startStream(tgt);
    topUp();
  endtask

  // Memory responder: grants per gnt_pct, answers in order after 1+extra cycles.
  always @(posedge w_clk) begin
    rst_seen = w_rst;
    if (w_rst) pend_q.delete();
    else begin
      if (w_imem_rvalid && beat_from_pend) void'(pend_q.pop_front());
      if (w_imem_req && w_imem_gnt)
        pend_q.push_back('{w_imem_addr, cyc + 1 + int'($urandom_range(extra_hi, extra_lo))});
    end
    cyc++;
    #2;
    beat_from_pend = 0; w_imem_rvalid = 0; w_imem_rdata = '0;
    if (stray) begin
      w_imem_rvalid = 1; w_imem_rdata = 32'hDEADBEEF;
    end else if (!w_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      w_imem_rvalid = 1; w_imem_rdata = mem_word(pend_q[0].addr); beat_from_pend = 1;
    end
    w_imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
  end

  // Monitor: pops the scoreboard on every accepted head and checks protocol rules.
  always @(negedge w_clk) begin
    if (w_rst) begin
      hold_pending = 0;
      if (rst_seen) begin
        checkOutput("rst_req", 32'(w_imem_req), 32'd0);
        checkOutput("rst_valid", 32'(w_if_valid), 32'd0);
        checkOutput("rst_pc", w_if_pc, 32'd0);
        checkOutput("rst_ir", w_if_ir, 32'd0);
        checkOutput("rst_addr", w_imem_addr, RESET_PC);
      end
    end else if (w_redir) begin
      hold_pending = 0;
      checkOutput("redir_valid", 32'(w_if_valid), 32'd0);
      checkOutput("redir_req", 32'(w_imem_req), 32'd0);
    end else begin
      if (hold_pending) begin
        checkOutput("hold_req", 32'(w_imem_req), 32'd1);
        checkOutput("hold_addr", w_imem_addr, hold_addr);
      end
      hold_pending = w_imem_req && !w_imem_gnt;
      hold_addr = w_imem_addr;
      if (w_if_valid && w_if_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL sb_underflow: got pc %h, expected no output", w_if_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("if_pc", w_if_pc, e.pc);
          checkOutput("if_ir", w_if_ir, e.ir);
        end
      end else if (!w_if_valid) begin
        checkOutput("idle_pc", w_if_pc, 32'd0);
        checkOutput("idle_ir", w_if_ir, 32'd0);
      end
    end
  end

  initial begin
    // Streaming at full rate
    repeat (3) applyStimulus(1, 0, 0, 1, 100, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    @(negedge w_clk); #1; snap = pop_cnt;
    repeat (16) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    @(negedge w_clk); #1;
    checkOutput("throughput", 32'(pop_cnt - snap), 32'd16);

    // Queue fills while decode stalls, then drains in order
    repeat (2) applyStimulus(1, 0, 0, 0, 100, 0, 0, 0);
    repeat (12) applyStimulus(0, 0, 0, 0, 100, 0, 0, 0);
    @(negedge w_clk); #1;
    checkOutput("full_req", 32'(w_imem_req), 32'd0);
    checkOutput("full_valid", 32'(w_if_valid), 32'd1);
    checkOutput("full_head_pc", w_if_pc, 32'h0);
    checkOutput("full_head_ir", w_if_ir, mem_word(32'h0));
    repeat (12) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);

    // Grant stall at 0x8
    repeat (2) applyStimulus(1, 0, 0, 1, 100, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    repeat (3) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge w_clk); #1;
      checkOutput("stall_addr", w_imem_addr, 32'h8);
      checkOutput("stall_req", 32'(w_imem_req), 32'd1);
    end
    repeat (10) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);

    // Two outstanding, then redirect to an unaligned target
    repeat (2) applyStimulus(1, 0, 0, 1, 100, 3, 3, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 100, 3, 3, 0);
    applyStimulus(0, 1, 32'h103, 1, 100, 0, 0, 0);
    repeat (15) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);

    // Redirect while a pop and a beat coincide
    repeat (2) applyStimulus(1, 0, 0, 1, 100, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    applyStimulus(0, 1, 32'h2000, 1, 100, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);

    // Address wrap, then reset mid-stream followed by a stray beat
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 100, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 1, 100, 1, 1, 0);
    repeat (2) applyStimulus(1, 0, 0, 1, 100, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1);
    repeat (10) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, d;
      r = ($urandom_range(199, 0) == 0);
      d = !r && ($urandom_range(99, 0) < 3);
      applyStimulus(r, d, $urandom(), ($urandom_range(99, 0) < 70), 70, 0, 2, 0);
    end
    repeat (3) applyStimulus(0, 0, 0, 1, 100, 0, 0, 0);
    @(negedge w_clk); #1;
    checkOutput("pops_seen", 32'(pop_cnt > 300), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
